// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: accepts one byte per tx_enable in IDLE and shifts it out LSB first.
// State, line and done pulse are all registered; tx_busy decodes the state register.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       tx_enable,
  output logic [1:0] tx_state,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] baud_cnt, baud_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          tx_nxt, done_nxt;
  logic          baud_term;

  assign baud_term = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign tx_state  = state;
  assign tx_busy   = (state != IDLE);

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_idx;
    shreg_nxt = shreg;
    tx_nxt    = tx;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (tx_enable) begin
          shreg_nxt = data_in;
          tx_nxt    = 1'b0;
          baud_nxt  = '0;
          state_nxt = START;
        end
      end
      START: begin
        if (baud_term) begin
          baud_nxt  = '0;
          bit_nxt   = 3'd0;
          tx_nxt    = shreg[0];
          state_nxt = DATA;
        end else begin
          baud_nxt = baud_cnt + CW'(1);
        end
      end
      DATA: begin
        if (baud_term) begin
          baud_nxt  = '0;
          shreg_nxt = {1'b0, shreg[7:1]};
          // shreg[1] is the next bit, since the shift lands on the same edge
          if (bit_idx != 3'd7) begin
            bit_nxt = bit_idx + 3'd1;
            tx_nxt  = shreg[1];
          end else begin
            tx_nxt    = 1'b1;
            state_nxt = STOP;
          end
        end else begin
          baud_nxt = baud_cnt + CW'(1);
        end
      end
      STOP: begin
        if (baud_term) begin
          baud_nxt  = '0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          baud_nxt = baud_cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shreg    <= 8'd0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      shreg    <= shreg_nxt;
      tx       <= tx_nxt;
      tx_done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: expected frames are queued when a byte is driven and
// checked bit-time by bit-time by a line monitor that also checks state and done timing.
module tb_uart_tx_serializer;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       tx_enable = 1'b0;
  logic [1:0] tx_state;
  logic       tx_busy, tx_done, tx;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [9:0] sb[$];     // {stop, d7..d0, start}
  int         done_t[$];
  logic       in_frame = 1'b0;
  int         idx = 0;
  int         exp_st;
  logic [9:0] cur;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;
  vec_t vecs[3];

  uart_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .tx_enable(tx_enable),
    .tx_state(tx_state), .tx_busy(tx_busy), .tx_done(tx_done), .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line monitor, sampled just after the falling edge
  always @(negedge clk) begin
    #1;
    if (rst) begin
      in_frame = 1'b0;
      idx = 0;
    end else begin
      if (!in_frame) begin
        chk("idle_done", tx_done, 0);
        if (tx === 1'b0) begin
          if (sb.size() == 0) chk("frame_expected", sb.size(), 1);
          else begin
            cur = sb.pop_front();
            in_frame = 1'b1;
            idx = 0;
          end
        end
      end
      if (in_frame) begin
        exp_st = (idx >= 10*CPB) ? 0 : (idx < CPB) ? 1 : (idx < 9*CPB) ? 2 : 3;
        chk("tx_state", tx_state, exp_st);
        chk("tx_busy", tx_busy, int'(exp_st != 0));
        chk("tx_done", tx_done, int'(idx == 10*CPB));
        chk("tx_line", tx, (idx < 10*CPB) ? int'(cur[idx/CPB]) : 1);
        if (idx == 10*CPB) begin
          done_t.push_back(cyc);
          in_frame = 1'b0;
        end
        idx++;
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [9:0] f);
    @(negedge clk);
    data_in = d;
    tx_enable = 1'b1;
    sb.push_back(f);
    @(negedge clk);
    tx_enable = 1'b0;
    data_in = 8'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (tx_state == 2'd0 && n < 5) begin @(negedge clk); n++; end
    chk({name, "_went_busy"}, int'(tx_state != 2'd0), 1);
    n = 0;
    while (tx_state != 2'd0 && n < 60) begin @(negedge clk); n++; end
    chk({name, "_back_idle"}, tx_state, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nd, n;
    vecs[0] = '{8'h55, 10'b1_01010101_0};
    vecs[1] = '{8'h48, 10'b1_01001000_0};
    vecs[2] = '{8'h49, 10'b1_01001001_0};

    // reset and idle
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_state", tx_state, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_tx", tx, 1);
      chk("idle_state", tx_state, 0);
      chk("idle_busy", tx_busy, 0);
    end

    // single bytes with printer-style pacing on tx_state
    for (int i = 0; i < 3; i++) begin
      nd = done_t.size();
      send(vecs[i].data, vecs[i].frame);
      wait_idle("paced");
      @(negedge clk);
      chk("paced_done_count", done_t.size() - nd, 1);
    end

    // request during DATA is ignored
    nd = done_t.size();
    send(8'hA3, 10'b1_10100011_0);
    n = 0;
    while (tx_state != 2'd2 && n < 10) begin @(negedge clk); n++; end
    data_in = 8'hFF;
    tx_enable = 1'b1;
    @(negedge clk);
    tx_enable = 1'b0;
    wait_idle("ignore");
    repeat (50) @(negedge clk);
    chk("ignore_done_count", done_t.size() - nd, 1);
    chk("ignore_sb_empty", sb.size(), 0);

    // back-to-back with tx_enable held high
    @(negedge clk);
    data_in = 8'h00;
    tx_enable = 1'b1;
    sb.push_back(10'b1_00000000_0);
    n = 0;
    while (tx_state == 2'd0 && n < 5) begin @(negedge clk); n++; end
    data_in = 8'hFF;
    sb.push_back(10'b1_11111111_0);
    n = 0;
    while (tx_state != 2'd0 && n < 60) begin @(negedge clk); n++; end
    chk("b2b_first_idle", tx_state, 0);
    @(negedge clk);
    tx_enable = 1'b0;
    chk("b2b_second_accept", tx_state, 1);
    wait_idle("b2b");
    @(negedge clk);
    n = done_t.size();
    chk("b2b_done_gap", (n >= 2) ? done_t[n-1] - done_t[n-2] : -1, 10*CPB + 1);

    // reset in the middle of bit 3
    nd = done_t.size();
    send(8'h0F, 10'b1_00001111_0);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_tx", tx, 1);
    chk("midrst_state", tx_state, 0);
    chk("midrst_done", tx_done, 0);
    repeat (45) @(negedge clk);
    chk("midrst_no_done", done_t.size() - nd, 0);
    send(8'h81, 10'b1_10000001_0);
    wait_idle("after_rst");
    @(negedge clk);
    chk("after_rst_done_count", done_t.size() - nd, 1);

    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
